insn_prefetch: RTL and testbench
================================

Name: insn_prefetch

Overview:
- Instruction prefetch stage that fetches code words from memory at CS:IP.
- Splits each word into bytes and pushes them into the 6-byte instruction FIFO.
- That FIFO is drained by the opcode, ModR/M and immediate decoders.
- Handles odd-address fetches, flush/restart on control transfers, and FIFO back-pressure.

Parameters:
- FIFO_DEPTH, 6, depth of the downstream byte FIFO. Documentation only; space is signalled via fifo_full/fifo_nearly_full.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- load_new_ip  input  1  one-cycle pulse: flush and restart fetching at new_cs:new_ip
- new_cs  input  16  code segment for restart
- new_ip  input  16  offset for restart
- fetch_ip  output  16  offset of the next byte to be pushed (for IP tracking)
- fifo_wr_en  output  1  push fifo_wr_data this cycle
- fifo_wr_data  output  8  byte pushed
- fifo_full  input  1  FIFO has 0 free entries
- fifo_nearly_full  input  1  FIFO has at most 1 free entry
- fifo_reset  output  1  flush downstream FIFO
- mem_access  output  1  bus request, held until mem_ack
- mem_ack  input  1  one-cycle completion; mem_data valid this cycle
- mem_address  output  19  word address = physical[19:1]
- mem_data  input  16  read data, little-endian

Behaviour:
- Physical address: ({cs,4'b0} + ip) mod 2^20, computed in 20 bits; mem_address = bits [19:1].
- Reset (reset==0 at clk edge):
  - cs=0xFFFF, ip=0x0000 (fetch starts at physical 0xFFFF0).
  - state=IDLE; mem_access=0, fifo_wr_en=0, fifo_reset=0, fetch_ip=0.
  - Reset mid-bus-cycle drops the request; the bus is reset concurrently.
- States:
  - IDLE -> FETCH when !fifo_nearly_full && !fifo_full && !load_new_ip. mem_access asserts the cycle FETCH is entered.
  - FETCH: mem_access=1, mem_address stable. On mem_ack:
    - Even ip: push low byte in the ack cycle if !fifo_full (else latch it and go to PUSH_LO); latch high byte; go to PUSH_HI.
    - Odd ip: push high byte only (same stall rule, going to PUSH_HI if full); go to IDLE.
  - PUSH_LO: push latched low byte when !fifo_full, then go to PUSH_HI.
  - PUSH_HI: push latched high byte when !fifo_full, then go to IDLE.
- fetch_ip increments by 1 per pushed byte, mod 2^16. Wrap stays within the segment: 0xFFFF -> 0x0000 with cs unchanged.
- Word fetch at ip=0xFFFF is treated as odd: 1 byte, then ip=0x0000.
- fifo_wr_en never asserts while fifo_full=1; at most one push per cycle.
- Flush (load_new_ip=1):
  - fifo_reset=1 combinationally in that cycle; no push in that cycle.
  - cs/ip load new values at the edge; latched bytes are discarded.
  - If a bus cycle is in flight (FETCH, no ack yet): mem_access stays asserted until mem_ack and the returned data is discarded. Go to IDLE the cycle after ack.
  - If load_new_ip coincides with mem_ack: data discarded, go to IDLE.
  - Back-to-back load_new_ip pulses: the last one wins.
- Minimum latency: load_new_ip at cycle N; mem_access at N+1; with ack at N+2 the first byte is pushed at N+2 (even address).

Optional Feature:
- PREFETCH_PERF_COUNTERS_EN defined adds two outputs, both cleared by reset and saturating at 0xFFFF:
  - flush_count[15:0]: increments per load_new_ip.
  - stall_count[15:0]: increments each cycle a latched byte is held because fifo_full=1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, FIFO empty, mem_ack 1 cycle after request with data 0x90EA -> mem_address=0x7FFF8, pushes 0xEA then 0x90, fetch_ip=0x0002.
- load_new_ip cs=0x1000 ip=0x0003, data 0xCDAB -> mem_address=0x08001, single push 0xCD, fetch_ip=0x0004, next fetch word 0x08002.
- cs=0x2000 ip=0xFFFF, data 0x1234 -> push 0x12 only, fetch_ip=0x0000, next mem_address=0x10000 (phys 0x20000).
- fifo_full held high 3 cycles across the ack of 0x5678 at even ip -> no push while full; 0x78 then 0x56 follow release; stall_count=3 with PREFETCH_PERF_COUNTERS_EN.
- load_new_ip mid-FETCH, ack 2 cycles later with 0xBEEF -> fifo_reset pulses once, 0xBEEF never pushed, next request at new address after ack.
- load_new_ip in same cycle as mem_ack -> no push, fifo_reset=1, IDLE next; flush_count increments by 1.

Source files
------------

// File: rtl/insn_prefetch.sv
// Instruction prefetch stage: fetches code words at CS:IP and pushes them, one byte at a time, into the downstream 6-byte FIFO.
// Optional build macro PREFETCH_PERF_COUNTERS_EN adds the flush_count and stall_count outputs.
module insn_prefetch #(
  parameter int FIFO_DEPTH = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  output logic [15:0] fetch_ip,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  input  logic        fifo_full,
  input  logic        fifo_nearly_full,
  output logic        fifo_reset,
  output logic        mem_access,
  input  logic        mem_ack,
  output logic [18:0] mem_address,
  input  logic [15:0] mem_data
`ifdef PREFETCH_PERF_COUNTERS_EN
  ,
  output logic [15:0] flush_count,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PUSH_LO = 2'd2,
    PUSH_HI = 2'd3
  } state_t;

  if (FIFO_DEPTH < 1) begin : g_depth_check
    $error("insn_prefetch: FIFO_DEPTH must be positive");
  end

  // Word address = ({seg,4'b0} + off) >> 1. Bit 0 of the sum is off[0], so no carry leaves bit 0.
  function automatic logic [18:0] word_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 3'b000} + {4'b0000, off[15:1]};
  endfunction

  state_t      state_r, state_s;
  logic [15:0] cs_r, cs_s;
  logic [15:0] ip_r, ip_s;
  logic [7:0]  lo_r, lo_s;
  logic [7:0]  hi_r, hi_s;
  logic [18:0] addr_r, addr_s;
  logic        discard_r, discard_s;
  logic        stall_s;

  assign fetch_ip    = ip_r;
  assign mem_access  = (state_r == FETCH);
  assign mem_address = addr_r;
  assign fifo_reset  = load_new_ip;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      cs_r      <= 16'hFFFF;
      ip_r      <= 16'h0000;
      lo_r      <= 8'h00;
      hi_r      <= 8'h00;
      addr_r    <= 19'h7FFF8;
      discard_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cs_r      <= cs_s;
      ip_r      <= ip_s;
      lo_r      <= lo_s;
      hi_r      <= hi_s;
      addr_r    <= addr_s;
      discard_r <= discard_s;
    end
  end

  // Next-state, push and flush decisions.
  always_comb begin
    state_s      = state_r;
    cs_s         = cs_r;
    ip_s         = ip_r;
    lo_s         = lo_r;
    hi_s         = hi_r;
    addr_s       = addr_r;
    discard_s    = discard_r;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    stall_s      = 1'b0;
    if (load_new_ip) begin
      cs_s = new_cs;
      ip_s = new_ip;
      if ((state_r == FETCH) && !mem_ack) begin
        // Bus cycle still open: keep the request up, throw away its data later.
        discard_s = 1'b1;
      end else if (state_r == FETCH) begin
        state_s   = IDLE;
        discard_s = 1'b0;
      end else begin
        // FIFO is being flushed, so restart immediately at the new address.
        state_s   = FETCH;
        addr_s    = word_addr(new_cs, new_ip);
        discard_s = 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_nearly_full && !fifo_full) begin
            state_s = FETCH;
            addr_s  = word_addr(cs_r, ip_r);
          end else begin
            state_s = IDLE;
          end
        end
        FETCH: begin
          if (!mem_ack) begin
            state_s = FETCH;
          end else if (discard_r) begin
            state_s   = IDLE;
            discard_s = 1'b0;
          end else if (ip_r[0]) begin
            hi_s = mem_data[15:8];
            if (!fifo_full) begin
              fifo_wr_en   = 1'b1;
              fifo_wr_data = mem_data[15:8];
              ip_s         = ip_r + 16'd1;
              state_s      = IDLE;
            end else begin
              stall_s = 1'b1;
              state_s = PUSH_HI;
            end
          end else begin
            lo_s = mem_data[7:0];
            hi_s = mem_data[15:8];
            if (!fifo_full) begin
              fifo_wr_en   = 1'b1;
              fifo_wr_data = mem_data[7:0];
              ip_s         = ip_r + 16'd1;
              state_s      = PUSH_HI;
            end else begin
              stall_s = 1'b1;
              state_s = PUSH_LO;
            end
          end
        end
        PUSH_LO: begin
          if (!fifo_full) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = lo_r;
            ip_s         = ip_r + 16'd1;
            state_s      = PUSH_HI;
          end else begin
            stall_s = 1'b1;
          end
        end
        PUSH_HI: begin
          if (!fifo_full) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = hi_r;
            ip_s         = ip_r + 16'd1;
            state_s      = IDLE;
          end else begin
            stall_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

`ifdef PREFETCH_PERF_COUNTERS_EN
  logic [15:0] flush_cnt_r;
  logic [15:0] stall_cnt_r;

  assign flush_count = flush_cnt_r;
  assign stall_count = stall_cnt_r;

  // Saturating flush and stall event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flush_cnt_r <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else begin
      if (load_new_ip && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end
`else
  logic unused_stall_s;
  assign unused_stall_s = stall_s;
`endif

endmodule

// File: tb/tb_insn_prefetch.sv
// Directed, table-driven bench for insn_prefetch: one table row per clock cycle, plus hand-written reset sequences.
module tb_insn_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_new_ip;
  logic [15:0] new_cs, new_ip;
  logic [15:0] fetch_ip;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_full, fifo_nearly_full;
  logic        fifo_reset;
  logic        mem_access;
  logic        mem_ack;
  logic [18:0] mem_address;
  logic [15:0] mem_data;
`ifdef PREFETCH_PERF_COUNTERS_EN
  logic [15:0] flush_count, stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  insn_prefetch dut (
    .clk(clk), .reset(reset), .load_new_ip(load_new_ip), .new_cs(new_cs), .new_ip(new_ip),
    .fetch_ip(fetch_ip), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .fifo_nearly_full(fifo_nearly_full), .fifo_reset(fifo_reset),
    .mem_access(mem_access), .mem_ack(mem_ack), .mem_address(mem_address), .mem_data(mem_data)
`ifdef PREFETCH_PERF_COUNTERS_EN
    , .flush_count(flush_count), .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic        ld;
    logic [15:0] ncs, nip;
    logic        full, nf, ack;
    logic [15:0] data;
    logic        e_acc;
    logic [18:0] e_addr;
    logic        e_wr;
    logic [7:0]  e_wd;
    logic        e_rst;
    logic [15:0] e_ip;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ld, input logic [15:0] ncs, input logic [15:0] nip,
                              input logic full, input logic nf, input logic ack, input logic [15:0] data,
                              input logic e_acc, input logic [18:0] e_addr, input logic e_wr,
                              input logic [7:0] e_wd, input logic e_rst, input logic [15:0] e_ip);
    vec_t v;
    v.ld = ld; v.ncs = ncs; v.nip = nip; v.full = full; v.nf = nf; v.ack = ack; v.data = data;
    v.e_acc = e_acc; v.e_addr = e_addr; v.e_wr = e_wr; v.e_wd = e_wd; v.e_rst = e_rst; v.e_ip = e_ip;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    reset = 1'b0; load_new_ip = 1'b0; new_cs = 16'h0; new_ip = 16'h0;
    fifo_full = 1'b0; fifo_nearly_full = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;

    // Per-cycle table: inputs for the cycle, expected outputs in that same cycle.
    //                ld  ncs       nip      full nf  ack data      acc addr        wr  wd     rst ip
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0000)); // r0 idle after reset
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 19'h7FFF8, 0, 8'h0,  0, 16'h0000)); // r1 request
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 1, 16'h90EA, 1, 19'h7FFF8, 1, 8'hEA, 0, 16'h0000)); // r2 ack, low byte
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     1, 8'h90, 0, 16'h0001)); // r3 high byte
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 1, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0002)); // r4 hold idle
    vq.push_back(mk(1, 16'h1000, 16'h0003, 0, 1, 0, 16'h0,    0, 19'h0,     0, 8'h0,  1, 16'h0002)); // r5 flush
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 19'h08001, 0, 8'h0,  0, 16'h0003)); // r6 N+1 request
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 1, 16'hCDAB, 1, 19'h08001, 1, 8'hCD, 0, 16'h0003)); // r7 odd push
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0004)); // r8
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 19'h08002, 0, 8'h0,  0, 16'h0004)); // r9 next word
    vq.push_back(mk(1, 16'h2000, 16'hFFFF, 0, 0, 0, 16'h0,    1, 19'h08002, 0, 8'h0,  1, 16'h0004)); // r10 flush mid-fetch
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 19'h08002, 0, 8'h0,  0, 16'hFFFF)); // r11 still pending
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 1, 16'hBEEF, 1, 19'h08002, 0, 8'h0,  0, 16'hFFFF)); // r12 discarded ack
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'hFFFF)); // r13 idle
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 19'h17FFF, 0, 8'h0,  0, 16'hFFFF)); // r14 new address
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 1, 16'h1234, 1, 19'h17FFF, 1, 8'h12, 0, 16'hFFFF)); // r15 ip FFFF odd
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0000)); // r16 wrap
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 19'h10000, 0, 8'h0,  0, 16'h0000)); // r17 same segment
    vq.push_back(mk(0, 16'h0,    16'h0,    1, 0, 1, 16'h5678, 1, 19'h10000, 0, 8'h0,  0, 16'h0000)); // r18 ack while full
    vq.push_back(mk(0, 16'h0,    16'h0,    1, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0000)); // r19 stall
    vq.push_back(mk(0, 16'h0,    16'h0,    1, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0000)); // r20 stall
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     1, 8'h78, 0, 16'h0000)); // r21 release
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 1, 0, 16'h0,    0, 19'h0,     1, 8'h56, 0, 16'h0001)); // r22
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 1, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0002)); // r23
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0002)); // r24
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    1, 19'h10001, 0, 8'h0,  0, 16'h0002)); // r25
    vq.push_back(mk(1, 16'h3000, 16'h0010, 0, 0, 1, 16'hAAAA, 1, 19'h10001, 0, 8'h0,  1, 16'h0002)); // r26 flush with ack
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 1, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0010)); // r27 idle
    vq.push_back(mk(1, 16'h4000, 16'h0000, 0, 1, 0, 16'h0,    0, 19'h0,     0, 8'h0,  1, 16'h0010)); // r28 flush 1
    vq.push_back(mk(1, 16'h5000, 16'h0001, 0, 1, 0, 16'h0,    1, 19'h20000, 0, 8'h0,  1, 16'h0000)); // r29 flush 2
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 1, 1, 16'h9999, 1, 19'h20000, 0, 8'h0,  0, 16'h0001)); // r30 discarded
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0001)); // r31
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 0, 1, 16'h77CC, 1, 19'h28000, 1, 8'h77, 0, 16'h0001)); // r32 last wins
    vq.push_back(mk(0, 16'h0,    16'h0,    0, 1, 0, 16'h0,    0, 19'h0,     0, 8'h0,  0, 16'h0002)); // r33

    repeat (3) next_cycle();
    check("rst_mem_access", 32'(mem_access), 32'd0);
    check("rst_wr_en",      32'(fifo_wr_en), 32'd0);
    check("rst_fifo_reset", 32'(fifo_reset), 32'd0);
    check("rst_fetch_ip",   32'(fetch_ip),   32'h0);
`ifdef PREFETCH_PERF_COUNTERS_EN
    check("rst_flush_count", 32'(flush_count), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      load_new_ip = vq[i].ld; new_cs = vq[i].ncs; new_ip = vq[i].nip;
      fifo_full = vq[i].full; fifo_nearly_full = vq[i].nf;
      mem_ack = vq[i].ack; mem_data = vq[i].data;
      #1;
      check($sformatf("r%0d_mem_access", i), 32'(mem_access), 32'(vq[i].e_acc));
      if (vq[i].e_acc) check($sformatf("r%0d_mem_address", i), 32'(mem_address), 32'(vq[i].e_addr));
      check($sformatf("r%0d_wr_en", i), 32'(fifo_wr_en), 32'(vq[i].e_wr));
      if (vq[i].e_wr) check($sformatf("r%0d_wr_data", i), 32'(fifo_wr_data), 32'(vq[i].e_wd));
      check($sformatf("r%0d_fifo_reset", i), 32'(fifo_reset), 32'(vq[i].e_rst));
      check($sformatf("r%0d_fetch_ip", i), 32'(fetch_ip), 32'(vq[i].e_ip));
      next_cycle();
    end
    load_new_ip = 1'b0; mem_ack = 1'b0;

`ifdef PREFETCH_PERF_COUNTERS_EN
    check("flush_count", 32'(flush_count), 32'd5);
    check("stall_count", 32'(stall_count), 32'd3);
`endif

    // Reset in the middle of a bus cycle drops the request.
    fifo_nearly_full = 1'b0; fifo_full = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      next_cycle();
      seen = mem_access;
    end
    check("mid_bus_request_seen", 32'(seen), 32'd1);
    reset = 1'b0;
    next_cycle();
    check("mid_bus_reset_access", 32'(mem_access), 32'd0);
    check("mid_bus_reset_ip",     32'(fetch_ip),   32'h0);
    reset = 1'b1;
    next_cycle();
    check("restart_access",  32'(mem_access),  32'd1);
    check("restart_address", 32'(mem_address), 32'h7FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
